// File: rtl/select_out_pkg.sv
// Shared definitions for the select_out_arb funnel: operating modes and
// the bit layout of the select_v configuration word.
package select_out_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Index field occupies the bits below the mode bit, so an index that
    // does not fit in the channel range is still visible and can be flagged.
    localparam int SEL_IDX_LSB  = 0;
    localparam int SEL_MODE_BIT = 16;
    localparam int SEL_IDX_W    = SEL_MODE_BIT - SEL_IDX_LSB;

endpackage

// File: rtl/rr_grant.sv
// Rotate-priority picker: grants the first requester found scanning
// ptr_i, ptr_i+1, ... with wrap modulo funnelWidth.
module rr_grant #(
    parameter  int funnelWidth = 8,
    localparam int idxW        = $clog2(funnelWidth)
) (
    input  logic [funnelWidth-1:0] req_i,
    input  logic [idxW-1:0]        ptr_i,
    output logic [funnelWidth-1:0] gnt_o,
    output logic [idxW-1:0]        gnt_idx_o,
    output logic                   any_o
);

    // Scan from the pointer and stop at the first set request bit.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int k = 0; k < funnelWidth; k++) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= funnelWidth) j = j - funnelWidth;
            if (!any_o && req_i[j]) begin
                any_o     = 1'b1;
                gnt_idx_o = idxW'(j);
                gnt_o[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/select_out_arb.sv
// Funnels funnelWidth input pipes onto one registered output pipe, either
// from a programmed fixed channel or by round-robin over eligible channels.
//
// Handshake: a beat moves across an interface on a cycle where the source's
// RDY and the sink's ENA are both 1. On the output, out_deq__ENA while
// out_deq__RDY = 0 is ignored. On the inputs, in_deq__ENA[i] is only raised
// while in_first__RDY[i] = 1, and never while the output register is full
// and not being drained in the same cycle.
module select_out_arb
    import select_out_pkg::*;
#(
    parameter  int funnelWidth = 8,
    parameter  int width       = 16,
    localparam int idxW        = $clog2(funnelWidth)
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         select__ENA,
    input  logic [31:0]                  select_v,
    output logic                         select__RDY,
    input  logic                         mask__ENA,
    input  logic [funnelWidth-1:0]       mask_v,
    output logic                         mask__RDY,
    input  logic [funnelWidth*width-1:0] in_first,
    input  logic [funnelWidth-1:0]       in_first__RDY,
    output logic [funnelWidth-1:0]       in_deq__ENA,
    output logic [width-1:0]             out_first,
    output logic [idxW-1:0]              out_tag,
    output logic                         out_first__RDY,
    output logic                         out_deq__RDY,
    input  logic                         out_deq__ENA,
    output logic                         err_index,
    output logic [31:0]                  beat_count
);

    logic                   valid_q, valid_d;
    logic [width-1:0]       data_q, data_d;
    logic [idxW-1:0]        tag_q, tag_d;
    logic [idxW-1:0]        index_q, index_d;
    logic                   index_valid_q, index_valid_d;
    mode_e                  mode_q, mode_d;
    logic [idxW-1:0]        ptr_q, ptr_d;
    logic [funnelWidth-1:0] mask_q, mask_d;
    logic                   err_q, err_d;
    logic [31:0]            beat_q, beat_d;

    logic [funnelWidth-1:0] eligible;
    logic [funnelWidth-1:0] rr_gnt;
    logic [idxW-1:0]        rr_idx;
    logic                   rr_any;
    logic                   fix_any;
    logic [funnelWidth-1:0] gnt_oh;
    logic [idxW-1:0]        gnt_idx;
    logic                   gnt_any;
    logic                   drain;
    logic                   load;
    logic [width-1:0]       chan_data [funnelWidth];
    logic [SEL_IDX_W-1:0]   sel_idx_field;
    logic                   sel_bad;
    logic                   unused_sel_bits;

    for (genvar g = 0; g < funnelWidth; g++) begin : g_unpack
        assign chan_data[g] = in_first[g*width +: width];
    end

    assign sel_idx_field   = select_v[SEL_MODE_BIT-1:SEL_IDX_LSB];
    assign sel_bad         = 32'(sel_idx_field) >= 32'(funnelWidth);
    assign unused_sel_bits = ^select_v[31:SEL_MODE_BIT+1];

    assign eligible = mask_q & in_first__RDY;

    rr_grant #(.funnelWidth(funnelWidth)) u_rr_grant (
        .req_i     (eligible),
        .ptr_i     (ptr_q),
        .gnt_o     (rr_gnt),
        .gnt_idx_o (rr_idx),
        .any_o     (rr_any)
    );

    assign fix_any = index_valid_q && eligible[index_q];

    // Choose the grant source for the current mode.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = index_q;
        gnt_any = fix_any;
        if (mode_q == MODE_RR) begin
            gnt_oh  = rr_gnt;
            gnt_idx = rr_idx;
            gnt_any = rr_any;
        end else begin
            gnt_oh[index_q] = fix_any;
        end
    end

    // A legal pop frees the register; a grant refills it in the same cycle.
    assign drain = out_deq__ENA && valid_q;
    assign load  = (!valid_q || drain) && gnt_any;

    assign in_deq__ENA    = (load && nRST) ? gnt_oh : '0;
    assign out_first      = data_q;
    assign out_tag        = tag_q;
    assign out_first__RDY = valid_q;
    assign out_deq__RDY   = valid_q;
    assign err_index      = err_q;
    assign beat_count     = beat_q;
    assign select__RDY    = 1'b1;
    assign mask__RDY      = 1'b1;

    // Next state for output register, pointer, config, mask and counter.
    always_comb begin
        valid_d       = valid_q;
        data_d        = data_q;
        tag_d         = tag_q;
        index_d       = index_q;
        index_valid_d = index_valid_q;
        mode_d        = mode_q;
        ptr_d         = ptr_q;
        mask_d        = mask_q;
        err_d         = err_q;
        beat_d        = beat_q;

        if (drain) begin
            valid_d = 1'b0;
            beat_d  = beat_q + 32'd1;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = chan_data[gnt_idx];
            tag_d   = gnt_idx;
            if (mode_q == MODE_RR) begin
                ptr_d = (gnt_idx == idxW'(funnelWidth - 1)) ? '0 : gnt_idx + idxW'(1);
            end
        end
        // Config and mask writes land at the edge, so grants this cycle
        // still see the old values.
        if (select__ENA) begin
            index_d       = select_v[SEL_IDX_LSB +: idxW];
            mode_d        = mode_e'(select_v[SEL_MODE_BIT]);
            index_valid_d = !sel_bad;
            if (sel_bad) err_d = 1'b1;
        end
        if (mask__ENA) begin
            mask_d = mask_v;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q       <= 1'b0;
            data_q        <= '0;
            tag_q         <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            mode_q        <= MODE_FIXED;
            ptr_q         <= '0;
            mask_q        <= '1;
            err_q         <= 1'b0;
            beat_q        <= '0;
        end else begin
            valid_q       <= valid_d;
            data_q        <= data_d;
            tag_q         <= tag_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            mode_q        <= mode_d;
            ptr_q         <= ptr_d;
            mask_q        <= mask_d;
            err_q         <= err_d;
            beat_q        <= beat_d;
        end
    end

endmodule

// File: tb/tb_select_out_arb.sv
// Self-checking bench for select_out_arb: directed scenarios plus a random
// run against a behavioural model of the funnel.
module tb_select_out_arb;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int IW = 3;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            sel_ena;
    logic [31:0]     sel_v;
    logic            sel_rdy;
    logic            mask_ena;
    logic [N-1:0]    mask_v;
    logic            mask_rdy;
    logic [N*W-1:0]  in_first;
    logic [N-1:0]    rdy;
    logic [N-1:0]    in_deq;
    logic [W-1:0]    out_first;
    logic [IW-1:0]   out_tag;
    logic            out_valid;
    logic            out_deq_rdy;
    logic            deq;
    logic            err_index;
    logic [31:0]     beat_count;
    logic [W-1:0]    dat [N];

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    bit              m_valid;
    logic [W-1:0]    m_data;
    int              m_tag;
    int              m_index;
    bit              m_ivalid;
    bit              m_mode;
    int              m_ptr;
    logic [N-1:0]    m_mask;
    bit              m_err;
    logic [31:0]     m_beats;
    logic [N-1:0]    exp_deq;
    logic [N-1:0]    obs_deq;
    logic [IW+W-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign in_first[g*W +: W] = dat[g];
    end

    select_out_arb dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .select__ENA    (sel_ena),
        .select_v       (sel_v),
        .select__RDY    (sel_rdy),
        .mask__ENA      (mask_ena),
        .mask_v         (mask_v),
        .mask__RDY      (mask_rdy),
        .in_first       (in_first),
        .in_first__RDY  (rdy),
        .in_deq__ENA    (in_deq),
        .out_first      (out_first),
        .out_tag        (out_tag),
        .out_first__RDY (out_valid),
        .out_deq__RDY   (out_deq_rdy),
        .out_deq__ENA   (deq),
        .err_index      (err_index),
        .beat_count     (beat_count)
    );

    function automatic void model_reset();
        m_valid  = 0;
        m_data   = '0;
        m_tag    = 0;
        m_index  = 0;
        m_ivalid = 0;
        m_mode   = 0;
        m_ptr    = 0;
        m_mask   = '1;
        m_err    = 0;
        m_beats  = '0;
        exp_q.delete();
    endfunction

    // Channel the model would grant this cycle, or -1.
    function automatic int model_grant();
        logic [N-1:0] elig;
        if (m_valid && !deq) return -1;
        elig = m_mask & rdy;
        if (!m_mode) return (m_ivalid && elig[m_index]) ? m_index : -1;
        for (int k = 0; k < N; k++) begin
            if (elig[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Advance one clock: inputs were driven at the previous negedge.
    task automatic step();
        int  g;
        int  idx;
        bit  drain;
        #4;
        g       = model_grant();
        exp_deq = (g >= 0) ? (N'(1) << g) : '0;
        obs_deq = in_deq;
        @(posedge CLK);
        drain = deq && m_valid;
        if (drain) begin
            m_beats = m_beats + 1;
            m_valid = 0;
        end
        if (g >= 0) begin
            m_valid = 1;
            m_data  = dat[g];
            m_tag   = g;
            exp_q.push_back({IW'(g), dat[g]});
            if (m_mode) m_ptr = (g + 1) % N;
        end
        if (sel_ena) begin
            idx    = int'(sel_v[15:0]);
            m_mode = sel_v[16];
            if (idx >= N) begin
                m_ivalid = 0;
                m_err    = 1;
            end else begin
                m_ivalid = 1;
                m_index  = idx;
            end
        end
        if (mask_ena) m_mask = mask_v;
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        sel_ena  = 0;
        sel_v    = '0;
        mask_ena = 0;
        mask_v   = '0;
        rdy      = '0;
        deq      = 0;
    endtask

    task automatic drain_out();
        idle_inputs();
        deq = 1;
        step();
        deq = 0;
    endtask

    task automatic test_reset();
        nRST = 0;
        idle_inputs();
        for (int i = 0; i < N; i++) dat[i] = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        nRST = 1;
        rdy  = '1;
        step();
        n_vec++;
        if (out_valid !== 1'b0 || out_first !== '0 || out_tag !== '0) begin
            n_err++;
            $display("FAIL reset_out: valid=%0b data=%h tag=%0d, want 0/0/0", out_valid, out_first, out_tag);
        end
        n_vec++;
        if (err_index !== 1'b0 || beat_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_status: err=%0b beats=%0d, want 0/0", err_index, beat_count);
        end
        n_vec++;
        if (obs_deq !== 8'h00 || sel_rdy !== 1'b1 || mask_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_deq: in_deq=%b sel_rdy=%0b mask_rdy=%0b, want 0/1/1", obs_deq, sel_rdy, mask_rdy);
        end
    endtask

    task automatic test_fixed();
        idle_inputs();
        sel_ena = 1;
        sel_v   = 32'd3;
        step();
        sel_ena = 0;
        rdy     = 8'b0000_1000;
        dat[3]  = 16'hBEEF;
        step();
        n_vec++;
        if (obs_deq !== 8'b0000_1000) begin
            n_err++;
            $display("FAIL fixed_deq: in_deq=%b, want 00001000", obs_deq);
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_first !== 16'hBEEF || out_tag !== 3'd3) begin
            n_err++;
            $display("FAIL fixed_out: valid=%0b data=%h tag=%0d, want 1/beef/3", out_valid, out_first, out_tag);
        end
        step();
        n_vec++;
        if (obs_deq !== 8'h00 || out_deq_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL fixed_one_shot: in_deq=%b deq_rdy=%0b, want 0/1", obs_deq, out_deq_rdy);
        end
        drain_out();
        n_vec++;
        if (out_valid !== 1'b0 || beat_count !== m_beats) begin
            n_err++;
            $display("FAIL fixed_pop: valid=%0b beats=%0d, want 0/%0d", out_valid, beat_count, m_beats);
        end
    endtask

    task automatic test_rr_all();
        logic [31:0] b0;
        idle_inputs();
        sel_ena = 1;
        sel_v   = 32'h0001_0000;
        step();
        sel_ena = 0;
        b0      = m_beats;
        rdy     = '1;
        deq     = 1;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) dat[i] = W'($urandom);
            step();
            n_vec++;
            if (out_valid !== 1'b1 || out_tag !== IW'(k % N) || out_first !== m_data) begin
                n_err++;
                $display("FAIL rr_seq[%0d]: valid=%0b tag=%0d data=%h, want 1/%0d/%h", k, out_valid, out_tag, out_first, k % N, m_data);
            end
        end
        n_vec++;
        if (beat_count !== b0 + 32'd9) begin
            n_err++;
            $display("FAIL rr_beats: beats=%0d, want %0d", beat_count, b0 + 32'd9);
        end
        drain_out();
    endtask

    task automatic test_mask();
        int prev;
        idle_inputs();
        mask_ena = 1;
        mask_v   = 8'b1010_0000;
        step();
        mask_ena = 0;
        rdy      = 8'b1010_0000;
        deq      = 1;
        prev     = -1;
        for (int k = 0; k < 6; k++) begin
            dat[5] = W'($urandom);
            dat[7] = W'($urandom);
            step();
            n_vec++;
            if (obs_deq !== exp_deq || (obs_deq & 8'b0101_1111) !== 8'h00) begin
                n_err++;
                $display("FAIL mask_deq[%0d]: in_deq=%b, want %b", k, obs_deq, exp_deq);
            end
            n_vec++;
            if ((out_tag !== 3'd5 && out_tag !== 3'd7) || int'(out_tag) == prev || out_first !== m_data) begin
                n_err++;
                $display("FAIL mask_tag[%0d]: tag=%0d data=%h, want alternating 5/7 data %h", k, out_tag, out_first, m_data);
            end
            prev = int'(out_tag);
        end
        idle_inputs();
        deq      = 1;
        mask_ena = 1;
        mask_v   = '1;
        step();
        deq = 0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        idle_inputs();
        deq     = 1;
        sel_ena = 1;
        sel_v   = 32'd2;
        step();
        idle_inputs();
        rdy    = 8'b0000_0100;
        dat[2] = W'($urandom);
        held   = dat[2];
        step();
        for (int k = 0; k < 4; k++) begin
            dat[2] = W'($urandom);
            step();
            n_vec++;
            if (obs_deq !== 8'h00 || out_first !== held || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: in_deq=%b data=%h valid=%0b, want 0/%h/1", k, obs_deq, out_first, out_valid, held);
            end
        end
        dat[2] = W'($urandom);
        held   = dat[2];
        deq    = 1;
        step();
        n_vec++;
        if (obs_deq !== 8'b0000_0100 || out_first !== held || beat_count !== m_beats) begin
            n_err++;
            $display("FAIL bp_release: in_deq=%b data=%h beats=%0d, want 00000100/%h/%0d", obs_deq, out_first, beat_count, held, m_beats);
        end
        drain_out();
    endtask

    task automatic test_bad_index();
        idle_inputs();
        sel_ena = 1;
        sel_v   = 32'd9;
        step();
        sel_ena = 0;
        n_vec++;
        if (err_index !== 1'b1) begin
            n_err++;
            $display("FAIL bad_err: err=%0b, want 1", err_index);
        end
        rdy = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (obs_deq !== 8'h00 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL bad_nogrant[%0d]: in_deq=%b valid=%0b, want 0/0", k, obs_deq, out_valid);
            end
        end
        sel_ena = 1;
        sel_v   = 32'd1;
        step();
        sel_ena = 0;
        n_vec++;
        if (obs_deq !== 8'h00) begin
            n_err++;
            $display("FAIL bad_old_cfg: in_deq=%b, want 0", obs_deq);
        end
        step();
        n_vec++;
        if (obs_deq !== 8'b0000_0010 || err_index !== 1'b1 || out_tag !== 3'd1) begin
            n_err++;
            $display("FAIL bad_restore: in_deq=%b err=%0b tag=%0d, want 00000010/1/1", obs_deq, err_index, out_tag);
        end
        drain_out();
    endtask

    task automatic test_random();
        logic [IW+W-1:0] want;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            sel_ena  = ($urandom_range(0, 15) == 0);
            sel_v    = {15'($urandom), 1'($urandom), 16'($urandom_range(0, 9))};
            mask_ena = ($urandom_range(0, 15) == 0);
            mask_v   = N'($urandom);
            rdy      = N'($urandom);
            deq      = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) dat[i] = W'($urandom);
            if (deq && out_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_sb_empty[%0d]: tag=%0d data=%h popped with no expected beat", c, out_tag, out_first);
                end else begin
                    want = exp_q.pop_front();
                    if ({out_tag, out_first} !== want) begin
                        n_err++;
                        $display("FAIL rand_sb[%0d]: tag/data=%h, want %h", c, {out_tag, out_first}, want);
                    end
                end
            end
            step();
            n_vec++;
            if (obs_deq !== exp_deq) begin
                n_err++;
                $display("FAIL rand_deq[%0d]: in_deq=%b, want %b", c, obs_deq, exp_deq);
            end
            n_vec++;
            if (out_valid !== m_valid || out_deq_rdy !== m_valid || beat_count !== m_beats || err_index !== m_err) begin
                n_err++;
                $display("FAIL rand_status[%0d]: valid=%0b beats=%0d err=%0b, want %0b/%0d/%0b", c, out_valid, beat_count, err_index, m_valid, m_beats, m_err);
            end
            if (m_valid) begin
                n_vec++;
                if (out_first !== m_data || out_tag !== IW'(m_tag)) begin
                    n_err++;
                    $display("FAIL rand_out[%0d]: data=%h tag=%0d, want %h/%0d", c, out_first, out_tag, m_data, m_tag);
                end
            end
        end
        drain_out();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        sel_ena = 1;
        sel_v   = 32'h0001_0000;
        mask_ena = 1;
        mask_v   = 8'h0F;
        step();
        idle_inputs();
        rdy = '1;
        step();
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ares_full: valid=%0b, want 1", out_valid);
        end
        #3;
        nRST = 0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || beat_count !== 32'd0 || in_deq !== 8'h00) begin
            n_err++;
            $display("FAIL ares_now: valid=%0b beats=%0d in_deq=%b, want 0/0/0", out_valid, beat_count, in_deq);
        end
        model_reset();
        @(negedge CLK);
        n_vec++;
        if (in_deq !== 8'h00 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ares_hold: in_deq=%b valid=%0b, want 0/0", in_deq, out_valid);
        end
        nRST = 1;
        idle_inputs();
        sel_ena = 1;
        sel_v   = 32'h0001_0000;
        step();
        sel_ena = 0;
        rdy     = 8'h80;
        step();
        n_vec++;
        if (obs_deq !== 8'h80) begin
            n_err++;
            $display("FAIL ares_mask7: in_deq=%b, want 10000000", obs_deq);
        end
        deq = 1;
        for (int k = 0; k < 6; k++) begin
            rdy = N'($urandom) | 8'h80;
            step();
            n_vec++;
            if (obs_deq !== exp_deq) begin
                n_err++;
                $display("FAIL ares_mask[%0d]: in_deq=%b, want %b", k, obs_deq, exp_deq);
            end
        end
        drain_out();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_all();
        test_mask();
        test_backpressure();
        test_bad_index();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/select_out_arb.md
Name: select_out_arb

Overview:
- Parametrised successor to the fixed-index pipe funnel: selects one of funnelWidth PipeOut-style input channels onto one output pipe.
- Two modes: software-programmed fixed index, or round-robin arbitration over ready, unmasked channels.
- Adds a registered output stage carrying data plus a source-channel tag, a per-channel enable mask, a bad-index error flag and a beat counter.
- Sits between per-source queues and a shared downstream consumer, for example a DMA or a network egress.

Parameters:
- funnelWidth, 8, number of input channels (>=2).
- width, 16, data width per channel.
- idxW, $clog2(funnelWidth), localparam, channel index width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- select__ENA  in  1  config write strobe.
- select$v  in  32  [idxW-1:0] index; [16] mode (0 = fixed, 1 = round-robin).
- select__RDY  out  1  always 1.
- mask__ENA  in  1  mask write strobe.
- mask$v  in  funnelWidth  per-channel enable; 1 = eligible.
- mask__RDY  out  1  always 1.
- in_first  in  funnelWidth*width  packed channel data; channel i at [i*width +: width].
- in_first__RDY  in  funnelWidth  channel i has data.
- in_deq__ENA  out  funnelWidth  pops channel i; one-hot or zero.
- out_first  out  width  registered data.
- out_tag  out  idxW  source channel of out_first.
- out_first__RDY  out  1  output register valid.
- out_deq__RDY  out  1  equals out_first__RDY.
- out_deq__ENA  in  1  consumer pop; legal only when out_deq__RDY.
- err_index  out  1  sticky; set when a programmed index is >= funnelWidth.
- beat_count  out  32  beats delivered.

Behaviour:
- Reset is asynchronous on the nRST falling edge. Reset values:
  - out valid 0; out_first 0; out_tag 0.
  - index 0; indexValid 0; mode 0.
  - rr pointer 0; mask all ones.
  - err_index 0; beat_count 0.
- Mid-operation reset discards the buffered beat; no in_deq__ENA is asserted while nRST = 0.
- Config write (select__ENA):
  - Captures index and mode and sets indexValid = 1.
  - If index >= funnelWidth: indexValid = 0 and err_index = 1. err_index is cleared only by reset.
  - The new config takes effect the cycle after the write. A grant made in the same cycle uses the old config.
- Mask write (mask__ENA): same timing as a config write.
- Eligibility: eligible[i] = mask[i] && in_first__RDY[i].
- Load condition: load = (!valid || out_deq__ENA) && (grant exists). Full throughput: one beat per cycle when load and drain overlap.
- Grant in fixed mode: channel index if indexValid && eligible[index]; otherwise no grant.
- Grant in round-robin mode:
  - Grant the first eligible channel scanning ptr, ptr+1, … with wrap modulo funnelWidth.
  - On load, ptr <= grant+1, wrapping funnelWidth-1 -> 0.
  - No load: ptr holds.
  - indexValid is ignored in this mode.
- On load:
  - in_deq__ENA[grant] = 1 in the same cycle.
  - out_first <= the granted channel's data; out_tag <= grant; valid <= 1.
- On out_deq__ENA without load: valid <= 0.
- Latency: in_first__RDY high to out_first__RDY high is 1 cycle when the register is empty.
- in_deq__ENA is never asserted while the register holds data and out_deq__ENA is 0 (backpressure).
- beat_count increments on each out_deq__ENA and wraps at 2^32.
- Mode switch with a beat buffered: the beat is delivered unchanged; ptr is preserved across mode switches.
- Mask clear of a granted channel affects only grants from the next cycle on.
- out_deq__ENA while out_deq__RDY = 0 is a protocol error: ignored, no state change.

Decomposition:
- Package select_out_pkg:
  - mode enum {MODE_FIXED = 0, MODE_RR = 1}.
  - Constants SEL_IDX_LSB = 0 and SEL_MODE_BIT = 16.
- Sub-module rr_grant (funnelWidth): combinational rotate-priority picker.
  - Inputs: request vector and ptr.
  - Outputs: one-hot grant, grant index, any-valid.
- Top-level contents: config registers, output register, counter, fixed-mode mux.

Test Plan:
- Reset, then select$v = 3 (fixed), channel 3 ready with 0xBEEF -> next cycle out_first = 0xBEEF, out_tag = 3; in_deq__ENA = 0b00001000 for exactly one cycle.
- Round-robin mode, all 8 channels permanently ready, out_deq__ENA tied 1 -> out_tag sequence 0,1,2,…,7,0; one beat per cycle; beat_count = 9 after 9 pops.
- Round-robin mode, mask = 0b10100000, channels 5 and 7 ready -> tags alternate 5,7,5; in_deq__ENA is never set for a masked channel.
- Backpressure: register full, out_deq__ENA = 0 for 4 cycles with channel 2 ready -> in_deq__ENA stays 0 and out_first is stable; one pop then admits the next beat the same cycle.
- select$v = 9 with funnelWidth = 8 -> err_index = 1, no grants in fixed mode; a later select$v = 1 restores grants while err_index stays 1.
- nRST asserted asynchronously mid-stream with the register full -> out_first__RDY = 0 and beat_count = 0 immediately; mask = 0xFF after release.
